// File: rtl/whack_pkg.sv
// Shared defaults and FSM state encoding for the auto_player whack-a-mole bot.
package whack_pkg;

  localparam int NUM_HOLES_DEF  = 18;
  localparam int CLK_PER_MS_DEF = 50000;
  localparam int MS_W           = 16;

  typedef logic [2:0] ap_state_t;

  localparam ap_state_t ST_IDLE  = 3'd0;
  localparam ap_state_t ST_REACT = 3'd1;
  localparam ap_state_t ST_SCAN  = 3'd2;
  localparam ap_state_t ST_WHACK = 3'd3;
  localparam ap_state_t ST_GAP   = 3'd4;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: counts 0..CLK_PER_MS-1 and pulses tick for one cycle per wrap.
module ms_tick #(
  parameter int CLK_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_PER_MS - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  // clr wins so a freshly entered state never sees a stale tick
  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/auto_player.sv
// Automated whack-a-mole player: reacts to a new mole pattern, then toggles the
// switch of every still-present mole in ascending order. Optional AUTO_PLAYER_MISS_EN
// adds an LFSR that deliberately skips about one whack in eight.
module auto_player
  import whack_pkg::*;
#(
  parameter int NUM_HOLES   = NUM_HOLES_DEF,
  parameter int CLK_PER_MS  = CLK_PER_MS_DEF,
  parameter int REACTION_MS = 150,
  parameter int GAP_MS      = 50
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_HOLES-1:0] mole_positions,
  output logic [NUM_HOLES-1:0] switches,
  output logic                 busy,
  output logic [7:0]           whack_count
);

  localparam int IDX_W = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HOLES - 1);

  ap_state_t            state, state_nxt;
  logic [NUM_HOLES-1:0] snapshot;
  logic [NUM_HOLES-1:0] hit_vec;
  logic [IDX_W-1:0]     idx;
  logic [MS_W-1:0]      ms_cnt;
  logic                 tick, tmr_clr, recap, recap_raw;
  logic                 hit, last, react_done, gap_done, miss, whack_fire;

  ms_tick #(.CLK_PER_MS(CLK_PER_MS)) u_ms_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .tick  (tick)
  );

  // a hole only qualifies if it was in the reacted-to pattern and is still up now
  assign hit_vec    = snapshot & mole_positions;
  assign hit        = hit_vec[idx];
  assign last       = (idx == LAST_IDX);
  assign react_done = (ms_cnt >= MS_W'(REACTION_MS));
  assign gap_done   = (ms_cnt >= MS_W'(GAP_MS));

`ifdef AUTO_PLAYER_MISS_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      lfsr <= LFSR_SEED;
    else if (state_nxt == ST_WHACK && state != ST_WHACK) lfsr <= lfsr_next(lfsr);
  end

  assign miss = (lfsr[2:0] == 3'd0);
`else
  assign miss = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    recap_raw = 1'b0;
    case (state)
      ST_IDLE:
        if (mole_positions != '0 && mole_positions != snapshot) state_nxt = ST_REACT;
      ST_REACT:
        if (mole_positions != snapshot) recap_raw = 1'b1;
        else if (react_done)            state_nxt = ST_SCAN;
      ST_SCAN:
        if (hit)       state_nxt = ST_WHACK;
        else if (last) state_nxt = ST_IDLE;
      ST_WHACK:
        state_nxt = ST_GAP;
      ST_GAP:
        if (gap_done) state_nxt = last ? ST_IDLE : ST_SCAN;
      default:
        state_nxt = ST_IDLE;
    endcase
    if (!enable) state_nxt = ST_IDLE;
  end

  assign recap      = recap_raw && enable;
  assign tmr_clr    = (state_nxt != state) || recap;
  assign whack_fire = (state == ST_WHACK) && (state_nxt == ST_GAP) && !miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      snapshot    <= '0;
      idx         <= '0;
      ms_cnt      <= '0;
      switches    <= '0;
      whack_count <= '0;
    end else begin
      state <= state_nxt;

      if ((state == ST_IDLE && state_nxt == ST_REACT) || recap)
        snapshot <= mole_positions;

      if (state == ST_REACT && state_nxt == ST_SCAN)
        idx <= '0;
      else if ((state == ST_SCAN || state == ST_GAP) && state_nxt == ST_SCAN)
        idx <= idx + 1'b1;

      if (tmr_clr)                ms_cnt <= '0;
      else if (tick && ms_cnt != '1) ms_cnt <= ms_cnt + 1'b1;

      if (whack_fire) begin
        switches <= switches ^ (NUM_HOLES'(1) << idx);
        if (whack_count != 8'hFF) whack_count <= whack_count + 1'b1;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/auto_player.md
AUTO_PLAYER -- requirements
Module: auto_player

Interface
REQ-001 Parameter NUM_HOLES, default 18: width of the mole and switch vectors.
REQ-002 Parameter CLK_PER_MS, default 50000: clk cycles per millisecond tick.
REQ-003 Parameter REACTION_MS, default 150: delay from new mole pattern to first whack.
REQ-004 Parameter GAP_MS, default 50: hold time between successive whacks; 0 is legal.
REQ-005 clk  input  1  single system clock, 50 MHz; one clock; reset is asynchronous and active-low.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  game in progress; the player acts only while high.
REQ-008 mole_positions  input  NUM_HOLES  live mole pattern from the mole generator.
REQ-009 switches  output  NUM_HOLES  emulated slide switches; a whack on hole i toggles bit i.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 whack_count  output  8  number of toggles issued since reset, saturating at 255.

Function
REQ-012 States SHALL be IDLE, REACT, SCAN, WHACK, GAP.
REQ-013 IDLE: when enable=1 and mole_positions is nonzero and differs from the last captured snapshot, capture snapshot, clear ms timer, go to REACT.
REQ-014 REACT: after REACTION_MS ms ticks, set scan index to 0 and go to SCAN; a snapshot change in REACT recaptures the pattern and restarts the timer.
REQ-015 SCAN: examines one index per cycle, ascending; if snapshot[i] and mole_positions[i] are both 1, go to WHACK; otherwise i+1.
REQ-016 After index NUM_HOLES-1 with no hit, SCAN returns to IDLE (no wrap to 0); snapshot is retained so the same pattern is not re-whacked.
REQ-017 WHACK: toggles switches[i] for exactly one cycle-edge, increments whack_count (saturating), then goes to GAP.
REQ-018 GAP: waits GAP_MS ms ticks, then resumes SCAN at i+1; if GAP_MS=0, resumes on the next cycle.
REQ-019 A mole that disappears before its index is scanned SHALL be skipped with no toggle.
REQ-020 enable falling in any state SHALL return to IDLE on the next edge; switches hold their value (no clearing, which would toggle holes).
REQ-021 A snapshot change during SCAN or GAP SHALL be ignored until IDLE is reached.
REQ-022 The ms timer SHALL use a counter 0..CLK_PER_MS-1 that is cleared on every state entry; one tick SHALL occur per wrap.

Reset
REQ-023 On rst_n=0: state=IDLE, switches=0, whack_count=0, busy=0, snapshot=0, timers=0, LFSR=non-zero seed 8'hA5.
REQ-024 Reset deassertion mid-game SHALL resume from IDLE with no spurious toggle.

Configuration
REQ-025 With AUTO_PLAYER_MISS_EN defined, an 8-bit LFSR advances each WHACK entry; when its low 3 bits are 0, the whack SHALL be skipped (no toggle, no count), and GAP still applies.
REQ-026 Without AUTO_PLAYER_MISS_EN, the LFSR is absent and every qualifying mole is whacked.

Structure
REQ-027 Package whack_pkg SHALL hold the NUM_HOLES and CLK_PER_MS defaults and the auto_player state enum.
REQ-028 Sub-module ms_tick (CLK_PER_MS counter with clear and one-cycle tick output) SHALL be instantiated once.

Verification
Benches use NUM_HOLES=18, CLK_PER_MS=4, REACTION_MS=2, GAP_MS=1.
REQ-029 enable=1, moles 0x00005 -> bit0 toggles ~8 cycles later, bit2 after GAP; switches=0x00005, whack_count=2, then IDLE.
REQ-030 Moles 0x20000 held; mole cleared during REACT -> no toggle, whack_count=0, returns to IDLE.
REQ-031 enable dropped in GAP after first whack of 0x00003 -> IDLE next edge, switches=0x00001 held.
REQ-032 Pattern 0x00010 applied twice (same value) -> single toggle only; a new value 0x00100 -> bit8 toggles.
REQ-033 rst_n pulsed low during SCAN -> all outputs 0 immediately (async); no toggle after release.
REQ-034 With AUTO_PLAYER_MISS_EN, run 64 single-mole patterns -> skip count equals the LFSR-predicted count from seed 8'hA5.
